cpu_decode_queue: RTL

- Parametrised successor to the single-slot fetch/decode hand-off.
- Accepts raw instructions from fetch through a valid/ready handshake and decodes R/M/B formats on entry.
- Buffers decoded entries in a DEPTH-entry FIFO and presents the head to the register-read stage with backpressure.
- Adds a flush path, supervisor-mode privilege checking, illegal-opcode detection and TLB-exception pass-through.

---
 rtl/cpu_decode_pkg.sv | 152 +++++++++++++++
 rtl/cpu_sync_fifo.sv | 73 +++++++
 rtl/cpu_decode_queue.sv | 79 +++++++
 3 files changed

// File: rtl/cpu_decode_pkg.sv
// Shared types and the single decode function for the fetch/decode queue.
package cpu_decode_pkg;

  localparam int INSTR_W   = 32;
  localparam int VADDR_W   = 32;
  localparam int TLB_EXC_W = 2;

  // Raw instruction field boundaries (LSB of each field).
  localparam int OPC_LSB  = 25;
  localparam int DST_LSB  = 20;
  localparam int SRC1_LSB = 15;
  localparam int SRC2_LSB = 10;

  localparam int OPC_W   = INSTR_W - OPC_LSB;
  localparam int REG_W   = OPC_LSB - DST_LSB;
  localparam int LOW_W   = SRC2_LSB;
  localparam int M_OFF_W = SRC1_LSB;
  localparam int B_IMM_W = REG_W + LOW_W;
  localparam int J_IMM_W = 2 * REG_W + LOW_W;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD      = 7'h00,
    OP_SUB      = 7'h01,
    OP_MUL      = 7'h02,
    OP_LDB      = 7'h10,
    OP_LDW      = 7'h11,
    OP_STB      = 7'h12,
    OP_STW      = 7'h13,
    OP_MOV      = 7'h14,
    OP_BEQ      = 7'h30,
    OP_JUMP     = 7'h31,
    OP_TLBWRITE = 7'h32,
    OP_IRET     = 7'h33
  } opcode_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [LOW_W-1:0] low;
  } r_fmt_t;

  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   dst;
    logic [REG_W-1:0]   src1;
    logic [M_OFF_W-1:0] offset;
  } m_fmt_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [LOW_W-1:0] low;
  } b_fmt_t;

  typedef union packed {
    r_fmt_t r;
    m_fmt_t m;
    b_fmt_t b;
  } instr_t;

  typedef struct packed {
    logic [OPC_W-1:0]     opcode;
    logic [REG_W-1:0]     dst;
    logic [REG_W-1:0]     src1;
    logic [REG_W-1:0]     src2;
    logic [VADDR_W-1:0]   imm;
    logic [VADDR_W-1:0]   pc;
    logic                 writes_dst;
    logic                 uses_src2;
    logic                 is_mem;
    logic                 is_branch;
    logic                 illegal;
    logic                 priv_fault;
    logic [TLB_EXC_W-1:0] tlb_exc;
  } decoded_instr_t;

  // Fields that a format does not define are left at zero (imm) or the raw
  // field value (register indices) so the consumer sees deterministic data.
  function automatic decoded_instr_t decode_instr(
    input logic [INSTR_W-1:0]   instr,
    input logic [VADDR_W-1:0]   pc,
    input logic [TLB_EXC_W-1:0] exc,
    input logic                 priv
  );
    instr_t               u;
    decoded_instr_t       d;
    logic [B_IMM_W-1:0]   bimm;
    logic [J_IMM_W-1:0]   jimm;
    u    = instr;
    d    = '0;
    bimm = {u.b.dst, u.b.low};
    jimm = {u.b.dst, u.b.src2, u.b.low};
    d.opcode  = u.r.opcode;
    d.dst     = u.r.dst;
    d.src1    = u.r.src1;
    d.src2    = u.r.src2;
    d.pc      = pc;
    d.tlb_exc = exc;
    case (u.r.opcode)
      OP_ADD, OP_SUB, OP_MUL: begin
        d.writes_dst = 1'b1;
        d.uses_src2  = 1'b1;
      end
      OP_LDB, OP_LDW: begin
        d.imm        = {{(VADDR_W-M_OFF_W){u.m.offset[M_OFF_W-1]}}, u.m.offset};
        d.is_mem     = 1'b1;
        d.writes_dst = 1'b1;
      end
      OP_STB, OP_STW: begin
        // dst field carries the store-data register
        d.imm       = {{(VADDR_W-M_OFF_W){u.m.offset[M_OFF_W-1]}}, u.m.offset};
        d.is_mem    = 1'b1;
        d.src2      = u.m.dst;
        d.uses_src2 = 1'b1;
      end
      OP_MOV: begin
        d.imm        = {{(VADDR_W-M_OFF_W){u.m.offset[M_OFF_W-1]}}, u.m.offset};
        d.writes_dst = 1'b1;
      end
      OP_BEQ: begin
        d.imm       = {{(VADDR_W-B_IMM_W){bimm[B_IMM_W-1]}}, bimm};
        d.uses_src2 = 1'b1;
        d.is_branch = 1'b1;
      end
      OP_JUMP: begin
        d.imm       = {{(VADDR_W-J_IMM_W){jimm[J_IMM_W-1]}}, jimm};
        d.is_branch = 1'b1;
      end
      OP_TLBWRITE: begin
        d.uses_src2  = 1'b1;
        d.priv_fault = ~priv;
      end
      OP_IRET: begin
        d.priv_fault = ~priv;
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    // A faulting fetch must not update architectural state downstream.
    if (exc != '0) begin
      d.writes_dst = 1'b0;
      d.is_mem     = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/cpu_sync_fifo.sv
// Synchronous FIFO with flush, generic payload type; storage is not reset.
module cpu_sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0],
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  T              wdata_i,
  output T              rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  T                mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full queue refuses a push even when a pop happens in the same cycle.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Next pointer/occupancy; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cpu_decode_queue.sv
// Fetch-to-register-read queue: decodes on entry, buffers decoded entries.
module cpu_decode_queue
  import cpu_decode_pkg::*;
#(
  parameter int ADDR_W = VADDR_W,
  parameter int DEPTH  = 4,
  parameter int EXC_W  = TLB_EXC_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [ADDR_W-1:0]      in_pc,
  input  logic [EXC_W-1:0]       in_tlb_exc,
  input  logic                   priv_mode,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [6:0]             out_opcode,
  output logic [4:0]             out_dst,
  output logic [4:0]             out_src1,
  output logic [4:0]             out_src2,
  output logic [ADDR_W-1:0]      out_imm,
  output logic [ADDR_W-1:0]      out_pc,
  output logic                   out_writes_dst,
  output logic                   out_uses_src2,
  output logic                   out_is_mem,
  output logic                   out_is_branch,
  output logic                   out_illegal,
  output logic                   out_priv_fault,
  output logic [EXC_W-1:0]       out_tlb_exc,
  output logic [$clog2(DEPTH):0] count
);

  // The entry layout lives in the package, so the widths must agree with it.
  if (ADDR_W != VADDR_W || EXC_W != TLB_EXC_W || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("cpu_decode_queue: unsupported ADDR_W/EXC_W/DEPTH combination");
  end

  decoded_instr_t entry_in, head;
  logic           full, empty;

  assign entry_in = decode_instr(in_instr, in_pc, in_tlb_exc, priv_mode);

  cpu_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (decoded_instr_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .pop_i   (out_ready),
    .flush_i (flush),
    .wdata_i (entry_in),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign in_ready       = ~full;
  assign out_valid      = ~empty;
  assign out_opcode     = head.opcode;
  assign out_dst        = head.dst;
  assign out_src1       = head.src1;
  assign out_src2       = head.src2;
  assign out_imm        = head.imm;
  assign out_pc         = head.pc;
  assign out_writes_dst = head.writes_dst;
  assign out_uses_src2  = head.uses_src2;
  assign out_is_mem     = head.is_mem;
  assign out_is_branch  = head.is_branch;
  assign out_illegal    = head.illegal;
  assign out_priv_fault = head.priv_fault;
  assign out_tlb_exc    = head.tlb_exc;

endmodule
